// File: rtl/iir_inv_seq.sv
// Inverse (reconstruction) IIR filter built from cascaded second-order sections.
// One shared multiplier does one product per cycle, so each section takes 5 cycles per sample.
module iir_inv_seq #(
    parameter int N        = 2,
    parameter int BITWIDTH = 32,
    parameter int SECTIONS = (N + 1) / 2,
    parameter int FAC      = 20
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [BITWIDTH-1:0]             in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [BITWIDTH-1:0]             out_data,
    input  logic                            coef_we,
    input  logic [$clog2(5*SECTIONS)-1:0]   coef_addr,
    input  logic [BITWIDTH-1:0]             coef_data
);

    localparam int W    = BITWIDTH;
    localparam int NC   = 5 * SECTIONS;
    localparam int AW   = $clog2(NC);
    localparam int SW   = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
    localparam int PW   = 2 * W;
    localparam int ACCW = 2 * W + 3;

    localparam logic [W-1:0]           ONE     = {{(W-1){1'b0}}, 1'b1} << FAC;
    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                 state, state_nxt;
    logic [SW-1:0]          sec;
    logic [2:0]             k;
    logic signed [ACCW-1:0] acc;
    logic signed [W-1:0]    cur_v;
    logic signed [W-1:0]    coef [NC];
    logic signed [W-1:0]    v1 [SECTIONS];
    logic signed [W-1:0]    v2 [SECTIONS];
    logic signed [W-1:0]    u1 [SECTIONS];
    logic signed [W-1:0]    u2 [SECTIONS];

    logic [AW-1:0]          coef_idx;
    logic signed [W-1:0]    coef_sel, op_sel;
    logic signed [PW-1:0]   coef_ext, op_ext, prod;
    logic signed [ACCW-1:0] term, acc_nxt, shifted;
    logic signed [W-1:0]    u_sat;
    logic                   last_term, last_sec;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign last_term = (k == 3'd4);
    assign last_sec  = (sec == SW'(SECTIONS - 1));

    // Datapath: select one coefficient/operand pair, multiply, accumulate, round down and clamp.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        coef_idx = AW'(5 * int'(sec) + int'(k));
        coef_sel = coef[coef_idx];
        case (k)
            3'd0:    op_sel = cur_v;
            3'd1:    op_sel = v1[sec];
            3'd2:    op_sel = v2[sec];
            3'd3:    op_sel = u1[sec];
            3'd4:    op_sel = u2[sec];
            default: op_sel = '0;
        endcase
        coef_ext = {{W{coef_sel[W-1]}}, coef_sel};
        op_ext   = {{W{op_sel[W-1]}}, op_sel};
        prod     = coef_ext * op_ext;
        term     = {{3{prod[PW-1]}}, prod};
        if (k >= 3'd3) term = -term;
        acc_nxt  = (k == 3'd0) ? term : acc + term;
        shifted  = acc_nxt >>> FAC;
        if (shifted > SAT_MAX)      u_sat = SAT_MAX[W-1:0];
        else if (shifted < SAT_MIN) u_sat = SAT_MIN[W-1:0];
        else                        u_sat = shifted[W-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = MAC;
            MAC:     if (last_term && last_sec) state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sec      <= '0;
            k        <= '0;
            acc      <= '0;
            cur_v    <= '0;
            out_data <= '0;
            // NOTE: the coefficient and history arrays are reset because reset must restore identity filtering.
            for (int i = 0; i < NC; i++) coef[i] <= (i % 5 == 0) ? ONE : '0;
            for (int s = 0; s < SECTIONS; s++) begin
                v1[s] <= '0;
                v2[s] <= '0;
                u1[s] <= '0;
                u2[s] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (coef_we && (int'(coef_addr) < NC)) coef[coef_addr] <= coef_data;
                    if (in_valid) cur_v <= in_data;
                    sec <= '0;
                    k   <= '0;
                end
                MAC: begin
                    if (last_term) begin
                        acc     <= '0;
                        k       <= '0;
                        v2[sec] <= v1[sec];
                        v1[sec] <= cur_v;
                        u2[sec] <= u1[sec];
                        u1[sec] <= u_sat;
                        cur_v   <= u_sat;
                        if (last_sec) out_data <= u_sat;
                        else          sec      <= sec + 1'b1;
                    end else begin
                        acc <= acc_nxt;
                        k   <= k + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/iir_inv_seq.md
IIR_INV_SEQ -- requirements
Module: iir_inv_seq

Interface
REQ-001 The block SHALL have parameter N, default 2: filter order.
REQ-002 The block SHALL have parameter BITWIDTH, default 32: signed two's-complement sample and coefficient width.
REQ-003 The block SHALL have parameter SECTIONS, default (N+1)/2: number of second-order sections.
REQ-004 The block SHALL have parameter FAC, default 20: fractional bits of the fixed-point encoding, so 1.0 = 1<<FAC.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port in_valid, input, 1 bit: input sample present.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block accepts a sample.
REQ-009 The block SHALL have port in_data, input, BITWIDTH bits: encoded sample, the output of the matching forward filter.
REQ-010 The block SHALL have port out_valid, output, 1 bit: reconstructed sample present.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-012 The block SHALL have port out_data, output, BITWIDTH bits: reconstructed encoded sample.
REQ-013 The block SHALL have port coef_we, input, 1 bit: coefficient write strobe.
REQ-014 The block SHALL have port coef_addr, input, $clog2(5*SECTIONS) bits: coefficient index, = 5*s+k, section s, term k.
REQ-015 The block SHALL have port coef_data, input, BITWIDTH bits: signed coefficient value.

Function
REQ-016 Per section s, with input v, past inputs v1/v2 and past outputs u1/u2, the block SHALL compute u = sat((c0*v + c1*v1 + c2*v2 - c3*u1 - c4*u2) >>> FAC).
REQ-017 Each product SHALL be 2*BITWIDTH bits signed; the accumulator SHALL be 2*BITWIDTH+3 bits; >>> is arithmetic (floor); sat clamps to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
REQ-018 Sections SHALL be cascaded in index order 0..SECTIONS-1; section 0 input = accepted sample; final section output = out_data.
REQ-019 The block SHALL use one shared multiplier, one product per cycle.
REQ-020 FSM IDLE: in_ready=1; on in_valid the sample SHALL be latched and the FSM SHALL go to MAC.
REQ-021 FSM MAC: 5 cycles per section, terms k=0..4; after k=4 of section s the block SHALL update v2<=v1, v1<=v, u2<=u1, u1<=u for s; after the last section it SHALL go to OUT.
REQ-022 FSM OUT: out_valid=1 and out_data stable until out_ready=1; on that handshake cycle the FSM SHALL go to IDLE.
REQ-023 in_ready SHALL be 0 outside IDLE; out_valid SHALL be 0 outside OUT.
REQ-024 Latency: sample accepted in cycle t SHALL give out_valid in cycle t+5*SECTIONS+1; the minimum sample period is 5*SECTIONS+2 cycles.
REQ-025 Coefficient writes SHALL take effect only in IDLE; writes in MAC/OUT and writes with coef_addr >= 5*SECTIONS SHALL be ignored.
REQ-026 A coefficient write and an in_valid acceptance in the same IDLE cycle SHALL both occur, and the new coefficient SHALL apply to that sample.
REQ-027 Odd N SHALL be realised with the last section's c2=c4=0, written by software; the hardware SHALL impose no special case.

Reset
REQ-028 On rst=1 at a clock edge, FSM SHALL go to IDLE, in_ready=1 the following cycle, out_valid=0, out_data=0, all v1/v2/u1/u2=0, accumulator=0.
REQ-029 Reset SHALL load c0=1<<FAC and c1..c4=0 in every section, giving identity.
REQ-030 Reset mid-MAC or mid-OUT SHALL abort the sample with no output and no history update.

Verification
REQ-031 Defaults (N=2, FAC=20): rst, then in_data=1000 accepted at t -> out_valid at t+6, out_data=1000.
REQ-032 Write c1=-(1<<19) for s=0; impulse 1<<20 followed by 0, 0 -> outputs 1048576, -524288, 0.
REQ-033 Write c0=4<<20; input 0x40000000 -> output 0x7FFFFFFF; input 0xC0000000 -> output 0x80000000.
REQ-034 Hold out_ready=0 for 10 cycles in OUT -> out_valid and out_data stable and in_ready=0 throughout; release -> IDLE next cycle.
REQ-035 coef_we during MAC with c0=0 -> current and next sample unchanged (identity); rst asserted during MAC -> no out_valid and history zero, so the next sample 7 -> output 7.
